// File: rtl/booth_pp_accumulator.sv
// Sequential accumulator for radix-4 Booth partial products: consumes NPP encoded
// {Result, Sign} terms and presents the 2*WORDLEN-bit product with a valid/ready handshake.
module booth_pp_accumulator #(
    parameter int WORDLEN = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_pp_valid,
    output logic                   o_pp_ready,
    input  logic [WORDLEN:0]       i_pp_data,
    input  logic                   i_pp_sign,
    output logic                   o_prod_valid,
    input  logic                   i_prod_ready,
    output logic [2*WORDLEN-1:0]   o_prod_data,
    output logic                   o_busy
);
    localparam int NPP  = WORDLEN / 2;
    localparam int IDXW = $clog2(NPP) + 1;
    localparam int W2   = 2 * WORDLEN;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NPP - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [W2-1:0]   r_acc;
    logic [IDXW-1:0] r_idx;

    logic [W2-1:0]   w_sext;
    logic [W2-1:0]   w_term;
    logic [IDXW:0]   w_shamt;

    // Sign correction lands at the same weight as the term, so add it before shifting.
    assign w_sext  = {{(WORDLEN-1){i_pp_data[WORDLEN]}}, i_pp_data};
    assign w_shamt = (r_state == S_IDLE) ? '0 : {r_idx, 1'b0};
    assign w_term  = (w_sext + {{(W2-1){1'b0}}, i_pp_sign}) << w_shamt;

    assign o_pp_ready   = (r_state != S_DONE);
    assign o_prod_valid = (r_state == S_DONE);
    assign o_prod_data  = r_acc;
    assign o_busy       = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_pp_valid) begin
                    r_acc   <= w_term;
                    r_idx   <= IDXW'(1);
                    r_state <= S_ACC;
                end
                S_ACC: if (i_pp_valid) begin
                    r_acc <= r_acc + w_term;
                    r_idx <= r_idx + IDXW'(1);
                    if (r_idx == LAST_IDX) r_state <= S_DONE;
                end
                S_DONE: if (i_prod_ready) begin
                    r_idx   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
